pc_sequencer: RTL
=================

# pc_sequencer

Four-phase instruction sequencer and program counter for the 15-bit CPU, directly upstream of the fetch stage. It drives the 8-bit `P_COUNT` that fetch samples and issues one-cycle phase strobes (fetch, decode, execute, write-back) on a single clock. It inspects the fetched instruction word to resolve `jmp`, `je` and `hlt`.

## Interface
Parameters:
- `RESET_PC`, 8'h00, program counter value loaded on reset.

Ports:
- `CLK`, input, 1, system clock; all state updates on the rising edge.
- `RESET`, input, 1, synchronous, active-high reset.
- `RUN`, input, 1, start request; sampled only in IDLE.
- `INST`, input, 15, instruction word from fetch (`PROM_OUT`); valid from the cycle after `EN_FT`.
- `CMP_EQ`, input, 1, equal flag from the execute stage, produced by the most recent `cmp`.
- `STEP`, input, 1, single-step advance pulse; used only when `PC_SEQ_STEP_EN` is defined.
- `P_COUNT`, output, 8, current program counter.
- `EN_FT`, output, 1, fetch-phase strobe.
- `EN_DC`, output, 1, decode-phase strobe.
- `EN_EX`, output, 1, execute-phase strobe.
- `EN_WB`, output, 1, write-back-phase strobe.
- `HALTED`, output, 1, high once `hlt` has retired.
- `RETIRED`, output, 16, count of retired instructions; saturates at 16'hFFFF.

## Operation
- **States:** IDLE, FT, DC, EX, WB, HALT, and PAUSE (PAUSE exists only with the macro defined).
- **IDLE:** all strobes are low. `RUN`=1 moves to FT.
- **FT → DC → EX → WB:** each state lasts exactly one cycle. The matching `EN_*` strobe is high during that state and only that state. Exactly one strobe is high at a time.
- **DC:** `INST` is captured into an internal IR. Opcode = IR[14:11]; target = IR[7:0].
- **EX:** next_pc is computed from the opcode:
  - 4'b1100 (`jmp`): next_pc = target.
  - 4'b1011 (`je`): next_pc = target if `CMP_EQ`=1, else `P_COUNT`+1. `CMP_EQ` is sampled in EX.
  - any other opcode: next_pc = `P_COUNT`+1 (8-bit, 8'hFF wraps to 8'h00).
- **WB:**
  - `P_COUNT` ← next_pc.
  - `RETIRED` increments, saturating.
  - If opcode is 4'b1111 (`hlt`), go to HALT. `P_COUNT` still advances, so it points one past `hlt`.
  - Otherwise go to FT.
- **HALT:**
  - `HALTED`=1; all strobes are low; `P_COUNT` and `RETIRED` are frozen.
  - `RUN` is ignored. Only `RESET` exits HALT.
- **Reset:**
  - Values: `P_COUNT`=`RESET_PC`, strobes 0, `HALTED`=0, `RETIRED`=0, IR=0, state IDLE.
  - Reset asserted mid-instruction in any state aborts the instruction with no `P_COUNT` update. Reset has priority over every other input.
- `RUN` held high continuously has no effect beyond the IDLE→FT transition.

## Timing
- **Cycles per instruction:** 4.
- **First instruction:** the cycle after `RUN` is sampled in IDLE, FT is active with `P_COUNT`=`RESET_PC`.
- **`P_COUNT` stability:** stable through FT, DC and EX. It changes only on the WB→FT edge, so fetch sees the new PC during the next `EN_FT`.
- **`INST` contract:** `INST` must be valid during DC. Fetch registers it on the `EN_FT` edge.
- **`CMP_EQ` contract:** `CMP_EQ` must reflect the previous instruction's `cmp` by the EX cycle.
- **`HALTED` timing:** `HALTED` rises on the edge leaving WB of `hlt`, i.e. at the same time the FT strobe would otherwise start.
- **Output registration:** all outputs are registered. No combinational input-to-output path.

## Configuration
- **Macro:** `PC_SEQ_STEP_EN`.
- **Defined:**
  - WB goes to PAUSE instead of FT; `hlt` still goes to HALT.
  - PAUSE holds with all strobes low until a cycle with `STEP`=1, then goes to FT.
  - A `STEP` held high gives one instruction per 5 cycles.
  - `STEP` in other states is ignored.
- **Undefined:** PAUSE is not built; `STEP` is ignored; WB goes directly to FT.

## Test plan
- Reset, then `RUN` pulse with `INST`=15'b1001_0000_0000_000 (`ldh`) repeated:
  - `P_COUNT` reads 0,0,0,0,1,1,1,1,2…
  - Strobes cycle FT,DC,EX,WB.
  - `RETIRED`=3 after 12 cycles past the first FT.
- `INST`=`jmp 8` (15'b1100_0000_0001_000) at PC 13 → `P_COUNT`=8 in the next FT.
- `je 14` at PC 12:
  - with `CMP_EQ`=1 → next `P_COUNT`=14;
  - with `CMP_EQ`=0 → next `P_COUNT`=13.
- `hlt` at PC 14:
  - `HALTED`=1 and `P_COUNT`=15 after WB;
  - no further strobes for 20 cycles despite `RUN`=1.
- PC wrap and mid-instruction reset:
  - Non-branch at PC 8'hFF → `P_COUNT`=8'h00.
  - `RESET` asserted during EX → next cycle `P_COUNT`=0, IDLE, `RETIRED` cleared.
- With `PC_SEQ_STEP_EN`:
  - After WB, strobes stay low until a `STEP` pulse.
  - FT follows exactly one cycle after the `STEP` cycle.

Source files
------------

// File: rtl/pc_sequencer.sv
// Four-phase (FT/DC/EX/WB) instruction sequencer and 8-bit program counter feeding fetch.
// Latency: 4 cycles per instruction; every output is registered, no input-to-output comb path.
// Optional macro PC_SEQ_STEP_EN: single-step mode, WB parks in PAUSE until a STEP cycle.
module pc_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        RUN,
  input  logic [14:0] INST,
  input  logic        CMP_EQ,
  input  logic        STEP,
  output logic [7:0]  P_COUNT,
  output logic        EN_FT,
  output logic        EN_DC,
  output logic        EN_EX,
  output logic        EN_WB,
  output logic        HALTED,
  output logic [15:0] RETIRED
);

  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_JE  = 4'b1011;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FT,
    S_DC,
    S_EX,
    S_WB,
    S_HALT
`ifdef PC_SEQ_STEP_EN
    , S_PAUSE
`endif
  } state_t;

  state_t      state_q;
  logic [7:0]  pc_q;
  logic [7:0]  next_pc_q;
  logic [14:0] ir_q;
  logic [15:0] retired_q;
  logic        halted_q;
  logic        en_ft_q, en_dc_q, en_ex_q, en_wb_q;

  logic [3:0]  opcode;
  logic [7:0]  target;
  logic [7:0]  pc_inc;
  logic [7:0]  next_pc_d;

  // IR bits [10:8] are operand bits this block does not decode; STEP is unused without single-step.
  logic [3:0]  unused_bits;
  assign unused_bits = {STEP, ir_q[10:8]};

  assign opcode = ir_q[14:11];
  assign target = ir_q[7:0];
  assign pc_inc = pc_q + 8'd1;

  // Branch resolution, only consumed while in EX (CMP_EQ is sampled there).
  always_comb begin
    next_pc_d = pc_inc;
    case (opcode)
      OP_JMP:  next_pc_d = target;
      OP_JE:   next_pc_d = CMP_EQ ? target : pc_inc;
      default: next_pc_d = pc_inc;
    endcase
  end

  // Phase FSM with registered strobes; strobe for a state is set on the edge entering it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      next_pc_q <= RESET_PC;
      ir_q      <= '0;
      retired_q <= '0;
      halted_q  <= 1'b0;
      en_ft_q   <= 1'b0;
      en_dc_q   <= 1'b0;
      en_ex_q   <= 1'b0;
      en_wb_q   <= 1'b0;
    end else begin
      en_ft_q <= 1'b0;
      en_dc_q <= 1'b0;
      en_ex_q <= 1'b0;
      en_wb_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (RUN) begin
            state_q <= S_FT;
            en_ft_q <= 1'b1;
          end
        end
        S_FT: begin
          state_q <= S_DC;
          en_dc_q <= 1'b1;
        end
        S_DC: begin
          ir_q    <= INST;
          state_q <= S_EX;
          en_ex_q <= 1'b1;
        end
        S_EX: begin
          next_pc_q <= next_pc_d;
          state_q   <= S_WB;
          en_wb_q   <= 1'b1;
        end
        S_WB: begin
          // PC advances even for hlt, leaving it one past the halting instruction.
          pc_q <= next_pc_q;
          if (retired_q != 16'hFFFF) retired_q <= retired_q + 16'd1;
          if (opcode == OP_HLT) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else begin
`ifdef PC_SEQ_STEP_EN
            state_q <= S_PAUSE;
`else
            state_q <= S_FT;
            en_ft_q <= 1'b1;
`endif
          end
        end
`ifdef PC_SEQ_STEP_EN
        S_PAUSE: begin
          if (STEP) begin
            state_q <= S_FT;
            en_ft_q <= 1'b1;
          end
        end
`endif
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign P_COUNT = pc_q;
  assign EN_FT   = en_ft_q;
  assign EN_DC   = en_dc_q;
  assign EN_EX   = en_ex_q;
  assign EN_WB   = en_wb_q;
  assign HALTED  = halted_q;
  assign RETIRED = retired_q;

endmodule
